// File: rtl/lim_dec_timer.sv
// Four-digit BCD countdown timer (MM:SS style) with per-digit limits,
// load-time saturation, pause/resume and a one-cycle done pulse.

module lim_dec_digit #(
    parameter int L = 9
) (
    input  logic [3:0] d,
    input  logic       bin,
    input  logic [3:0] ld,
    output logic [3:0] q,
    output logic       bout,
    output logic [3:0] sat
);
    always_comb begin
        sat  = (ld > 4'(L)) ? 4'(L) : ld;
        q    = d;
        bout = 1'b0;
        if (bin) begin
            if (d == 4'd0) begin
                q    = 4'(L);
                bout = 1'b1;
            end else begin
                q = d - 4'd1;
            end
        end
    end
endmodule

module lim_dec_timer #(
    parameter int TICK_CYCLES = 100000000,
    parameter int MIN_TENS_L  = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] count,
    output logic        running,
    output logic        zero,
    output logic        done
);
    localparam int NUM_DIG = 4;
    localparam int PW      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t                    state_q, state_d;
    logic [NUM_DIG-1:0][3:0]   count_q, count_d;
    logic [NUM_DIG-1:0][3:0]   dec_val, sat_val;
    logic [NUM_DIG:0]          borrow;
    logic [PW-1:0]             presc_q, presc_d;
    logic                      done_q, done_d;

    // Digit 0 is sec_units; borrow ripples toward min_tens.
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
        localparam int DL = (i == 3) ? MIN_TENS_L : ((i == 1) ? 5 : 9);
        lim_dec_digit #(.L(DL)) u_dig (
            .d    (count_q[i]),
            .bin  (borrow[i]),
            .ld   (load_val[i*4 +: 4]),
            .q    (dec_val[i]),
            .bout (borrow[i+1]),
            .sat  (sat_val[i])
        );
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = IDLE;
            count_d = sat_val;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!stop && start && (count_q != '0)) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        // A borrow out of the top digit would be an underflow.
                        if (!borrow[NUM_DIG]) begin
                            count_d = dec_val;
                            if (dec_val == '0) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (!stop && start) state_d = RUN;
                end
                DONE:    ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    assign count   = count_q;
    assign running = (state_q == RUN);
    assign zero    = (count_q == '0);
    assign done    = done_q;
endmodule

// File: tb/tb_lim_dec_timer.sv
module tb_lim_dec_timer;
    localparam int TICK = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] count;
    logic        running, zero, done;

    lim_dec_timer #(.TICK_CYCLES(TICK), .MIN_TENS_L(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .count    (count),
        .running  (running),
        .zero     (zero),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          c;
        logic [15:0] cnt;
        logic        r;
        logic        z;
        logic        d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   stale = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && (sb[0].c <= cyc || stale)) begin
            e = sb.pop_front();
            checks++;
            if (e.c != cyc || count !== e.cnt || running !== e.r ||
                zero !== e.z || done !== e.d) begin
                failures++;
                $display("FAIL %s cyc=%0d (due %0d): count=%h running=%b zero=%b done=%b, expected count=%h running=%b zero=%b done=%b",
                         e.name, cyc, e.c, count, running, zero, done, e.cnt, e.r, e.z, e.d);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic ld, input logic [15:0] v, input logic st,
                         input logic sp, input logic rs);
        load = ld; load_val = v; start = st; stop = sp; reset = rs;
        tick(1);
        load = 1'b0; start = 1'b0; stop = 1'b0; reset = 1'b0;
    endtask

    task automatic exp_at(input string n, input int c, input logic [15:0] cnt,
                          input logic r, input logic z, input logic d);
        exp_t e;
        e.name = n; e.c = c; e.cnt = cnt; e.r = r; e.z = z; e.d = d;
        sb.push_back(e);
    endtask

    task automatic check_now(input string n, input logic [15:0] cnt,
                             input logic r, input logic z, input logic d);
        checks++;
        if (count !== cnt || running !== r || zero !== z || done !== d) begin
            failures++;
            $display("FAIL %s cyc=%0d: count=%h running=%b zero=%b done=%b, expected count=%h running=%b zero=%b done=%b",
                     n, cyc, count, running, zero, done, cnt, r, z, d);
        end
    endtask

    initial begin : stim
        int s;
        int r;
        tick(1);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        s = cyc;
        check_now("reset_now", 16'h0000, 1'b0, 1'b1, 1'b0);
        exp_at("reset_state", s, 16'h0000, 1'b0, 1'b1, 1'b0);
        exp_at("reset_idle", s + 1, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick(1);

        drive(1'b1, 16'h0102, 1'b0, 1'b0, 1'b0);
        exp_at("load_0102", cyc, 16'h0102, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'h0102, 1'b1, 1'b0, 1'b0);
        s = cyc;
        exp_at("start_run", s, 16'h0102, 1'b1, 1'b0, 1'b0);
        exp_at("pre_step", s + 3, 16'h0102, 1'b1, 1'b0, 1'b0);
        exp_at("step_0101", s + 4, 16'h0101, 1'b1, 1'b0, 1'b0);
        exp_at("step_0100", s + 8, 16'h0100, 1'b1, 1'b0, 1'b0);
        exp_at("borrow_0059", s + 12, 16'h0059, 1'b1, 1'b0, 1'b0);
        tick(12);

        drive(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        exp_at("sat_ffff", cyc, 16'h5959, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h6A0B, 1'b0, 1'b0, 1'b0);
        exp_at("sat_6a0b", cyc, 16'h5909, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
        s = cyc;
        exp_at("step_0001", s + 4, 16'h0001, 1'b1, 1'b0, 1'b0);
        exp_at("pre_zero", s + 7, 16'h0001, 1'b1, 1'b0, 1'b0);
        exp_at("done_pulse", s + 8, 16'h0000, 1'b0, 1'b1, 1'b1);
        exp_at("done_once", s + 9, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick(9);
        drive(1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
        exp_at("done_start_ign", cyc, 16'h0000, 1'b0, 1'b1, 1'b0);
        exp_at("done_hold", cyc + 5, 16'h0000, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 16'h0002, 1'b0, 1'b1, 1'b0);
        tick(4);
        check_now("done_hold_now", 16'h0000, 1'b0, 1'b1, 1'b0);

        drive(1'b1, 16'h0105, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'h0105, 1'b1, 1'b0, 1'b0);
        s = cyc;
        tick(3);
        drive(1'b1, 16'h0300, 1'b0, 1'b0, 1'b0);
        exp_at("load_on_wrap", s + 4, 16'h0300, 1'b0, 1'b0, 1'b0);
        exp_at("load_wrap_idle", s + 8, 16'h0300, 1'b0, 1'b0, 1'b0);
        tick(4);

        drive(1'b1, 16'h0105, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'h0105, 1'b1, 1'b0, 1'b0);
        s = cyc;
        exp_at("pause_step", s + 4, 16'h0104, 1'b1, 1'b0, 1'b0);
        tick(6);
        drive(1'b0, 16'h0105, 1'b0, 1'b1, 1'b0);
        exp_at("paused", s + 7, 16'h0104, 1'b0, 1'b0, 1'b0);
        exp_at("paused_hold", s + 16, 16'h0104, 1'b0, 1'b0, 1'b0);
        tick(10);
        drive(1'b0, 16'h0105, 1'b1, 1'b0, 1'b0);
        r = cyc;
        exp_at("resumed", r, 16'h0104, 1'b1, 1'b0, 1'b0);
        exp_at("resume_wait", r + 1, 16'h0104, 1'b1, 1'b0, 1'b0);
        exp_at("resume_step", r + 2, 16'h0103, 1'b1, 1'b0, 1'b0);
        tick(2);

        drive(1'b0, 16'h0105, 1'b1, 1'b1, 1'b0);
        exp_at("ss_run_pause", r + 3, 16'h0103, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'h0105, 1'b1, 1'b1, 1'b0);
        exp_at("ss_pause_hold", r + 8, 16'h0103, 1'b0, 1'b0, 1'b0);
        tick(4);

        drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        exp_at("zero_start_ign", cyc, 16'h0000, 1'b0, 1'b1, 1'b0);
        exp_at("zero_stay_idle", cyc + 5, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick(5);

        drive(1'b1, 16'h0031, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'h0031, 1'b1, 1'b0, 1'b0);
        s = cyc;
        exp_at("pre_reset_0030", s + 4, 16'h0030, 1'b1, 1'b0, 1'b0);
        tick(5);
        drive(1'b0, 16'h0031, 1'b1, 1'b0, 1'b1);
        exp_at("mid_reset", s + 6, 16'h0000, 1'b0, 1'b1, 1'b0);
        exp_at("post_reset", s + 7, 16'h0000, 1'b0, 1'b1, 1'b0);
        exp_at("post_reset_hold", s + 10, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick(4);

        for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
        if (sb.size() > 0) begin
            stale = 1'b1;
            tick(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lim_dec_timer.md
LIM_DEC_TIMER -- requirements
Module: lim_dec_timer

Interface
REQ-001 The block SHALL have parameter TICK_CYCLES, default 100000000, meaning the number of clock cycles per decrement step (1 Hz at 100 MHz).
REQ-002 The block SHALL have parameter MIN_TENS_L, default 5, meaning the upper limit of the most significant digit.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port load, input, 1 bit: load load_val into the count.
REQ-006 The block SHALL have port load_val, input, 16 bits: four BCD nibbles {min_tens, min_units, sec_tens, sec_units}.
REQ-007 The block SHALL have port start, input, 1 bit: begin or resume the countdown.
REQ-008 The block SHALL have port stop, input, 1 bit: pause the countdown.
REQ-009 The block SHALL have port count, output, 16 bits: the current four-digit value, in the same nibble order as load_val.
REQ-010 The block SHALL have port running, output, 1 bit: high while in RUN.
REQ-011 The block SHALL have port zero, output, 1 bit: high while count == 16'h0000.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the countdown reaches zero.

Function
REQ-013 The per-digit limits SHALL be: sec_units L=9, sec_tens L=5, min_units L=9, min_tens L=MIN_TENS_L.
REQ-014 On load, each nibble greater than its L SHALL saturate to L (e.g. load_val 16'h7F9A with MIN_TENS_L=5 -> 16'h5959).
REQ-015 Each decrement step SHALL apply a limited decrement with borrow to each digit: a digit with borrow-in 0 is unchanged; a digit >0 with borrow-in 1 decrements; a digit ==0 with borrow-in 1 wraps to its L and asserts borrow-out.
REQ-016 The borrow-in of sec_units SHALL be 1 on each step, and the borrow-out of each digit SHALL feed the next digit.
REQ-017 The FSM SHALL have states IDLE, RUN, PAUSE and DONE, with input priority reset > load > stop > start.
REQ-018 When load is high, the block SHALL go to IDLE from any state, write the saturated value, and clear the prescaler.
REQ-019 In IDLE, start with count != 0 SHALL move the FSM to RUN with the prescaler at 0; start with count == 0 SHALL be ignored.
REQ-020 In RUN, stop SHALL move the FSM to PAUSE while holding both count and prescaler.
REQ-021 In PAUSE, start SHALL move the FSM to RUN and the prescaler SHALL resume from its held value.
REQ-022 In RUN, the prescaler SHALL count 0..TICK_CYCLES-1.
REQ-023 When the prescaler equals TICK_CYCLES-1, it SHALL wrap to 0 and exactly one decrement step SHALL occur in the same cycle.
REQ-024 The first decrement SHALL occur TICK_CYCLES cycles after the start edge.
REQ-025 When a decrement step produces 16'h0000, the FSM SHALL enter DONE on that edge, and done SHALL be high for exactly the following cycle.
REQ-026 In DONE, start and stop SHALL be ignored, and only load or reset SHALL exit DONE.
REQ-027 When start and stop are high in the same cycle, stop SHALL win, so RUN goes to PAUSE and IDLE/PAUSE stay unchanged.
REQ-028 running, zero and done SHALL be registered or decoded from registered state only, with no combinational path from inputs.
REQ-029 Load together with a prescaler wrap SHALL load and SHALL NOT decrement.
REQ-030 The count SHALL never underflow below 16'h0000 and SHALL never leave the range 0..L in any digit.

Reset
REQ-031 On reset, the block SHALL set the state to IDLE, count to 16'h0000, prescaler to 0, running to 0, done to 0, and zero to 1.
REQ-032 Reset asserted mid-RUN SHALL abort the countdown with no done pulse, and the block SHALL ignore start on the reset cycle.

Verification (TICK_CYCLES=4)
REQ-033 The bench SHALL cover: load 16'h0102, start -> count 0101 after 4 cycles, then 0100, then 0059 (borrow wrap), with running=1 throughout.
REQ-034 The bench SHALL cover: load 16'h0002, start -> 0001, then 0000 eight cycles after start, then state DONE, done high for exactly 1 cycle, zero=1, running=0.
REQ-035 The bench SHALL cover: load 16'hFFFF -> count 5959 (saturation), and load 16'h6A0B -> 5909.
REQ-036 The bench SHALL cover: in RUN, stop 2 cycles after a step, wait 10 cycles, then start -> count unchanged during pause, and the next step 2 cycles after restart.
REQ-037 The bench SHALL cover: start+stop together in RUN -> PAUSE; start with count 0000 in IDLE -> stays IDLE, done=0.
REQ-038 The bench SHALL cover: reset mid-RUN at 16'h0030 -> next cycle count 0000, zero=1, done=0, state IDLE.
